flopr_pipe: RTL and testbench
=============================

// Module: flopr_pipe
// PURPOSE
//  Parametrised multi-stage resettable register chain with per-stage valid bits,
//  valid/ready back-pressure, bubble collapsing and synchronous flush. It
//  generalises the single flopr to a DEPTH-deep, WIDTH-wide elastic pipeline.
//  It sits between MIPS32 datapath stages, e.g. IF/ID/EX/MEM boundaries, and
//  absorbs stall and flush (branch mispredict) requests.
// PARAMETERS
//  WIDTH      32   data bits per stage
//  DEPTH      4    number of register stages (>=1)
//  RESET_VAL  0    value loaded into every data register on reset or flush
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            synchronous, active-low (0 = reset)
//  flush      in   1            synchronous clear of all stages
//  in_valid   in   1            upstream presents in_data
//  in_ready   out  1            chain accepts in_data this cycle
//  in_data    in   WIDTH        input word
//  out_valid  out  1            last stage holds a valid word
//  out_ready  in   1            downstream takes out_data this cycle
//  out_data   out  WIDTH        last-stage data
//  occupancy  out  clog2(DEPTH+1)  number of valid stages
// BEHAVIOUR
//  - Reset, sampled at posedge clk with reset==0: all valid bits=0 and all
//    data=RESET_VAL. Therefore out_valid=0, out_data=RESET_VAL, occupancy=0,
//    and in_ready=1 from the first cycle after reset.
//  - Stage i (0=input side, DEPTH-1=output) holds v[i] and d[i].
//  - Advance rule:
//      adv[DEPTH-1] = out_ready | ~v[DEPTH-1]
//      adv[i]       = adv[i+1] | ~v[i]
//    A stage loads from its predecessor when adv[i] is 1. Otherwise it holds.
//  - in_ready = adv[0]. This is combinational from out_ready and the valid bits.
//    There is no in_valid->in_ready path.
//  - Accept when in_valid & in_ready; the stage-0 valid then takes in_valid.
//    Transfer out when out_valid & out_ready.
//  - Bubble collapse: an empty stage always loads, so a stalled output still lets
//    upstream words fill the empty slots. At most DEPTH words are held.
//  - Latency with no stall: DEPTH cycles from accept to out_valid.
//    Throughput is 1 word per cycle.
//  - Data registers load only when the stage advances. Data in an invalid stage
//    is don't-care, but it is deterministic (last loaded value or RESET_VAL).
//  - flush==1: next cycle all v=0 and all d=RESET_VAL. A word offered on in_data
//    in the flush cycle is dropped, even if in_ready=1.
//    Precedence: reset > flush > advance.
//  - Full: all v=1 and out_ready=0 -> in_ready=0, and contents hold unchanged.
//  - Full with out_ready=1: out word leaves, and a new word is accepted in the
//    same cycle. Occupancy stays DEPTH.
//  - Empty: out_valid=0, and out_ready is ignored.
//  - occupancy is a registered popcount of v. It updates in the same cycle as v.
//  - Reset asserted mid-stream discards all contents. No partial output.
// STRUCTURE
//  - No package type is needed. A shared mips_pkg holds a clog2 function,
//    reused for the occupancy width.
//  - One sub-module, flopr_pipe_stage: one slot holding valid plus WIDTH data,
//    with inputs load, clr, d_in, v_in.
//  - The top instantiates DEPTH stages in a generate loop and computes the
//    adv chain and the popcount.
// TESTING  (WIDTH=32, DEPTH=4 unless noted)
//  1. Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0,
//     out_data=0, occupancy=0, in_ready=1.
//  2. Stream: out_ready=1, push 0..11 on consecutive cycles -> 0 appears 4
//     cycles after accept. The outputs are 0..11 in order, with no gaps.
//  3. Back-pressure: out_ready=0, push 1,2,3,4,5 -> in_ready drops after 4
//     accepts and occupancy=4. Then out_ready=1 -> outputs 1,2,3,4,5.
//  4. Bubble collapse: push 7, idle 2 cycles, push 8, with out_ready=0 ->
//     7 and 8 end up in adjacent stages and occupancy=2. Release -> 7 then 8
//     on back-to-back cycles.
//  5. Flush: pipe holds 3 words, then flush=1 with in_valid=1, in_data=9 ->
//     next cycle occupancy=0 and out_valid=0. Word 9 never appears.
//  6. Full and drain together: full pipe, out_ready=1, push 0xA each cycle ->
//     occupancy stays 4, and one word leaves per cycle in FIFO order.
//     Repeat with DEPTH=1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared helpers for the MIPS32 datapath blocks
package mips_pkg;

  // Ceiling log2; a counter able to hold values 0..n-1 needs clog2(n) bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/flopr_pipe_stage.sv
// rtl/flopr_pipe_stage.sv - one pipeline slot: a valid bit plus WIDTH data bits
module flopr_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clr,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_v <= 1'b0;
      r_d <= RESET_VAL;
    end else if (load) begin
      r_v <= v_in;
      r_d <= d_in;
    end
  end

  assign v_out = r_v;
  assign d_out = r_d;

endmodule

// File: rtl/flopr_pipe.sv
// rtl/flopr_pipe.sv - DEPTH-deep elastic register chain with back-pressure,
// bubble collapsing and synchronous flush
module flopr_pipe
  import mips_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OCC_W     = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_adv;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_accept;
  logic             w_leave;
  logic [OCC_W-1:0] r_occ;

  // A stage may advance when the one ahead advances or when it is itself
  // empty; empty slots therefore always absorb upstream words.
  always_comb begin
    w_adv            = '0;
    w_adv[DEPTH-1]   = out_ready | ~w_v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = w_adv[i+1] | ~w_v[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_first
        flopr_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
          .clk   (clk),
          .reset (reset),
          .load  (w_adv[g]),
          .clr   (flush),
          .v_in  (in_valid),
          .d_in  (in_data),
          .v_out (w_v[g]),
          .d_out (w_d[g])
        );
      end else begin : g_rest
        flopr_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
          .clk   (clk),
          .reset (reset),
          .load  (w_adv[g]),
          .clr   (flush),
          .v_in  (w_v[g-1]),
          .d_in  (w_d[g-1]),
          .v_out (w_v[g]),
          .d_out (w_d[g])
        );
      end
    end
  endgenerate

  assign in_ready  = w_adv[0];
  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign w_accept  = in_valid & in_ready;
  assign w_leave   = out_valid & out_ready;

  // Words are conserved by the chain, so tracking accepts minus departures
  // yields the popcount of the valid bits registered alongside them.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_leave})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_flopr_pipe.sv
// tb/tb_flopr_pipe.sv - randomized and directed checks of flopr_pipe (DEPTH 4 and 1)
module tb_flopr_pipe;

  typedef struct {
    logic [31:0] d;
    int          pos;
  } ent_t;
  typedef ent_t ent_q_t[$];

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        rdy4, ov4, rdy1, ov1;
  logic [31:0] od4, od1;
  logic [2:0]  occ4;
  logic [0:0]  occ1;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     chk_on   = 1'b0;
  bit     cleared  = 1'b0;
  ent_q_t q4, q1;

  always #5 clk = ~clk;

  flopr_pipe #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .occupancy(occ4)
  );

  flopr_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a FIFO of words each tagged with its slot index. A word moves
  // one slot forward per cycle unless the slot ahead is still taken.
  task automatic model_eval(input ent_q_t q, input int depth, output logic rdy,
                            output logic ov, output logic [31:0] od, output int occ);
    occ = q.size();
    ov  = (occ > 0) && (q[0].pos == depth - 1);
    od  = ov ? q[0].d : 32'h0;
    rdy = (occ < depth) || out_ready;
  endtask

  task automatic model_step(inout ent_q_t q, input int depth);
    bit   acc;
    int   lim;
    int   np;
    ent_t e;
    if (!reset || flush) begin
      q.delete();
    end else begin
      acc = in_valid && ((q.size() < depth) || out_ready);
      if (q.size() > 0 && q[0].pos == depth - 1 && out_ready) void'(q.pop_front());
      lim = depth - 1;
      for (int i = 0; i < q.size(); i++) begin
        e  = q[i];
        np = (e.pos + 1 > lim) ? lim : e.pos + 1;
        e.pos = np;
        q[i]  = e;
        lim   = np - 1;
      end
      if (acc) begin
        e.d   = in_data;
        e.pos = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] id, input logic ordy);
    logic        e_rdy, e_ov;
    logic [31:0] e_od;
    int          e_occ;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    if (chk_on) begin
      model_eval(q4, 4, e_rdy, e_ov, e_od, e_occ);
      check("d4_in_ready", 32'(rdy4), 32'(e_rdy));
      check("d4_out_valid", 32'(ov4), 32'(e_ov));
      check("d4_occupancy", 32'(occ4), 32'(e_occ));
      if (e_ov) check("d4_out_data", od4, e_od);
      if (cleared) check("d4_out_data_cleared", od4, 32'h0);
      model_eval(q1, 1, e_rdy, e_ov, e_od, e_occ);
      check("d1_in_ready", 32'(rdy1), 32'(e_rdy));
      check("d1_out_valid", 32'(ov1), 32'(e_ov));
      check("d1_occupancy", 32'(occ1), 32'(e_occ));
      if (e_ov) check("d1_out_data", od1, e_od);
      if (cleared) check("d1_out_data_cleared", od1, 32'h0);
    end
    @(posedge clk);
    model_step(q4, 4);
    model_step(q1, 1);
    cleared = !rst || fl;
  endtask

  function automatic bit will_accept4(input logic ordy);
    return (q4.size() < 4) || ordy;
  endfunction

  initial begin
    int  k;
    bit  a;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    cycle(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    chk_on = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming 0..11 with no stall
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i), 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Back-pressure: offer 1..5, upstream holds a word until accepted
    k = 1;
    repeat (7) begin
      a = will_accept4(1'b0);
      cycle(1'b1, 1'b0, k <= 5, 32'(k), 1'b0);
      if (k <= 5 && a) k++;
    end
    repeat (10) begin
      a = will_accept4(1'b1);
      cycle(1'b1, 1'b0, k <= 5, 32'(k), 1'b1);
      if (k <= 5 && a) k++;
    end

    // Bubble collapse
    cycle(1'b1, 1'b0, 1'b1, 32'd7, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'd8, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with a word offered in the same cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h30 + 32'(i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'd9, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Full pipe draining and refilling in the same cycles
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'h40 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h60 + 32'(i), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h66, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
